// File: rtl/passcode_attempt_controller.sv
// Passcode entry sequencer: collects BCD keypad digits, checks a full code, counts failures, times lockout.
// Latency: every output is registered; the verdict appears one cycle after the CHECK cycle that follows the last digit.
// Backpressure: none; digits arriving in CHECK/UNLOCKED/LOCKOUT are dropped, and so are non-BCD digits.
//
// Ports:
//   Clock, Reset     rising-edge clock, synchronous active-high reset
//   Digit_In         keypad digit (BCD 0..9, qualified by Digit_Valid)
//   Digit_Valid      one-cycle strobe for Digit_In
//   Clear            abandon the entry in progress (ENTRY only)
//   Relock           leave UNLOCKED
//   Attempt_Count    failures so far, 4'hF while locked out (feeds the 7-segment decoder)
//   Entry_Pos        digits collected in the current entry
//   Unlocked         high while UNLOCKED
//   Locked_Out       high while LOCKOUT
//   Fail_Pulse       one-cycle strobe per wrong code
module passcode_attempt_controller #(
  parameter int                      CODE_LEN      = 4,
  parameter logic [4*CODE_LEN-1:0]   PASSCODE      = 16'h1234,
  parameter int                      MAX_TRIES     = 4,
  parameter int                      LOCK_CYCLES   = 1000,
  parameter int                      ENTRY_TIMEOUT = 500
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Digit_In,
  input  logic       Digit_Valid,
  input  logic       Clear,
  input  logic       Relock,
  output logic [3:0] Attempt_Count,
  output logic [2:0] Entry_Pos,
  output logic       Unlocked,
  output logic       Locked_Out,
  output logic       Fail_Pulse
);

  // One timer serves both the inter-digit timeout and the lockout,
  // since the two are never active at the same time.
  localparam int TMAX = (LOCK_CYCLES > ENTRY_TIMEOUT) ? LOCK_CYCLES : ENTRY_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = 4 * CODE_LEN;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_UNLOCKED,
    ST_LOCKOUT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   code_q, code_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      count_d;
  logic [2:0]      pos_d;
  logic            unlocked_d;
  logic            locked_d;
  logic            fail_d;
  logic            digit_ok;
  logic            last_digit;

  assign digit_ok   = Digit_Valid && (Digit_In <= 4'd9);
  // Compared in int so CODE_LEN=8 is recognised even though the 3-bit
  // Entry_Pos wraps to 0 while sitting in CHECK.
  assign last_digit = (int'(Entry_Pos) + 1) == CODE_LEN;

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    timer_d    = timer_q;
    count_d    = Attempt_Count;
    pos_d      = Entry_Pos;
    unlocked_d = Unlocked;
    locked_d   = Locked_Out;
    fail_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (digit_ok) begin
          code_d  = {code_q[CW-5:0], Digit_In};
          pos_d   = 3'd1;
          timer_d = '0;
          state_d = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (Clear) begin
          pos_d   = '0;
          code_d  = '0;
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (digit_ok) begin
          code_d  = {code_q[CW-5:0], Digit_In};
          pos_d   = Entry_Pos + 3'd1;
          timer_d = '0;
          if (last_digit) begin
            state_d = ST_CHECK;
          end
        end else if (timer_q == TW'(ENTRY_TIMEOUT - 1)) begin
          // Idle for ENTRY_TIMEOUT cycles since the last accepted digit.
          pos_d   = '0;
          code_d  = '0;
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_CHECK: begin
        pos_d   = '0;
        code_d  = '0;
        timer_d = '0;
        if (code_q == PASSCODE) begin
          count_d    = '0;
          unlocked_d = 1'b1;
          state_d    = ST_UNLOCKED;
        end else if ((int'(Attempt_Count) + 1) < MAX_TRIES) begin
          count_d = Attempt_Count + 4'd1;
          fail_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          // The decoder renders 4'hF as "F", marking lockout on the display.
          count_d  = 4'hF;
          fail_d   = 1'b1;
          locked_d = 1'b1;
          state_d  = ST_LOCKOUT;
        end
      end

      ST_UNLOCKED: begin
        if (Relock) begin
          unlocked_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      ST_LOCKOUT: begin
        // timer_q is 0 on the first lockout cycle, so exiting at
        // LOCK_CYCLES-1 holds Locked_Out for exactly LOCK_CYCLES cycles.
        if (timer_q == TW'(LOCK_CYCLES - 1)) begin
          timer_d  = '0;
          locked_d = 1'b0;
          count_d  = '0;
          state_d  = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      default: begin
        state_d    = ST_IDLE;
        code_d     = '0;
        timer_d    = '0;
        count_d    = '0;
        pos_d      = '0;
        unlocked_d = 1'b0;
        locked_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q       <= ST_IDLE;
      code_q        <= '0;
      timer_q       <= '0;
      Attempt_Count <= '0;
      Entry_Pos     <= '0;
      Unlocked      <= 1'b0;
      Locked_Out    <= 1'b0;
      Fail_Pulse    <= 1'b0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      timer_q       <= timer_d;
      Attempt_Count <= count_d;
      Entry_Pos     <= pos_d;
      Unlocked      <= unlocked_d;
      Locked_Out    <= locked_d;
      Fail_Pulse    <= fail_d;
    end
  end

endmodule

// File: tb/tb_passcode_attempt_controller.sv
module tb_passcode_attempt_controller;

  localparam int          CL = 4;
  localparam int          MT = 4;
  localparam int          LC = 8;
  localparam int          ET = 16;
  localparam logic [15:0] PC = 16'h1234;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Digit_In = 4'd0;
  logic       Digit_Valid = 1'b0;
  logic       Clear = 1'b0;
  logic       Relock = 1'b0;
  logic [3:0] Attempt_Count;
  logic [2:0] Entry_Pos;
  logic       Unlocked;
  logic       Locked_Out;
  logic       Fail_Pulse;

  int checks = 0;
  int errors = 0;

  passcode_attempt_controller #(
    .CODE_LEN(CL), .PASSCODE(PC), .MAX_TRIES(MT),
    .LOCK_CYCLES(LC), .ENTRY_TIMEOUT(ET)
  ) dut (
    .Clock(Clock), .Reset(Reset), .Digit_In(Digit_In), .Digit_Valid(Digit_Valid),
    .Clear(Clear), .Relock(Relock), .Attempt_Count(Attempt_Count), .Entry_Pos(Entry_Pos),
    .Unlocked(Unlocked), .Locked_Out(Locked_Out), .Fail_Pulse(Fail_Pulse)
  );

  always #5 Clock = ~Clock;

  logic [9:0] dut_vec;
  assign dut_vec = {Attempt_Count, Entry_Pos, Unlocked, Locked_Out, Fail_Pulse};

  // Reference model: digits collected so far, failure tally, remaining
  // lockout cycles, unlocked flag, and cycles since the last digit.
  int m_q[$];
  int m_fails, m_lock_left, m_age;
  bit m_unl, m_pend, m_fail;

  function automatic void model_step(bit rst, bit dv, logic [3:0] d, bit clr, bit rl);
    int v;
    if (rst) begin
      m_q.delete(); m_fails = 0; m_lock_left = 0; m_age = 0;
      m_unl = 0; m_pend = 0; m_fail = 0;
      return;
    end
    m_fail = 0;
    if (m_pend) begin
      v = 0;
      foreach (m_q[i]) v = v * 16 + m_q[i];
      if (v == int'(PC)) begin
        m_unl = 1; m_fails = 0;
      end else begin
        m_fails++; m_fail = 1;
        if (m_fails >= MT) m_lock_left = LC;
      end
      m_q.delete(); m_pend = 0;
    end else if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_unl) begin
      if (rl) m_unl = 0;
    end else if (m_q.size() > 0 && clr) begin
      m_q.delete();
    end else if (dv && d <= 4'd9) begin
      m_q.push_back(int'(d)); m_age = 0;
      if (m_q.size() == CL) m_pend = 1;
    end else if (m_q.size() > 0) begin
      m_age++;
      if (m_age >= ET) m_q.delete();
    end
  endfunction

  function automatic logic [9:0] exp_vec();
    logic [3:0] c;
    c = (m_lock_left > 0) ? 4'hF : 4'(m_fails);
    return {c, 3'(m_q.size()), m_unl, (m_lock_left > 0), m_fail};
  endfunction

  task automatic drive(input bit rst, input bit dv, input logic [3:0] d, input bit clr, input bit rl);
    Reset = rst; Digit_Valid = dv; Digit_In = d; Clear = clr; Relock = rl;
    @(posedge Clock);
    model_step(rst, dv, d, clr, rl);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 4'd0, 0, 0);
  endtask

  task automatic test_reset();
    drive(1, 1, 4'd1, 1, 1);
    drive(1, 0, 4'd0, 0, 0);
    checks++;
    if (dut_vec !== 10'h000) begin
      errors++; $display("FAIL reset_values: got %h expected %h", dut_vec, 10'h000);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_model: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_unlock();
    int code[4] = '{1, 2, 3, 4};
    bit fail_seen = 0;
    drive(1, 0, 4'd0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 4'(code[i]), 0, 0);
      fail_seen |= Fail_Pulse;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL unlock_digit%0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (Entry_Pos !== 3'd4 || Unlocked !== 1'b0) begin
      errors++; $display("FAIL unlock_check_cycle: got pos=%0d unl=%b expected pos=4 unl=0", Entry_Pos, Unlocked);
    end
    idle();
    fail_seen |= Fail_Pulse;
    checks++;
    if (Unlocked !== 1'b1 || Attempt_Count !== 4'd0 || Entry_Pos !== 3'd0 || fail_seen) begin
      errors++; $display("FAIL unlock_result: got unl=%b cnt=%h pos=%0d fail=%b expected 1 0 0 0",
                         Unlocked, Attempt_Count, Entry_Pos, fail_seen);
    end
  endtask

  task automatic test_wrong_then_right();
    int bad[4]  = '{1, 2, 3, 5};
    int good[4] = '{1, 2, 3, 4};
    drive(1, 0, 4'd0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 4'(bad[i]), 0, 0);
    idle();
    checks++;
    if (Fail_Pulse !== 1'b1 || Attempt_Count !== 4'd1 || Entry_Pos !== 3'd0 || Unlocked !== 1'b0) begin
      errors++; $display("FAIL wrong_code: got fail=%b cnt=%h pos=%0d unl=%b expected 1 1 0 0",
                         Fail_Pulse, Attempt_Count, Entry_Pos, Unlocked);
    end
    idle();
    checks++;
    if (Fail_Pulse !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL wrong_pulse_width: got %h expected %h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 4; i++) drive(0, 1, 4'(good[i]), 0, 0);
    idle();
    checks++;
    if (Unlocked !== 1'b1 || Attempt_Count !== 4'd0) begin
      errors++; $display("FAIL right_after_wrong: got unl=%b cnt=%h expected 1 0", Unlocked, Attempt_Count);
    end
  endtask

  task automatic test_lockout();
    int bad[4]  = '{9, 8, 7, 6};
    int good[4] = '{1, 2, 3, 4};
    logic [3:0] want;
    int high_cycles;
    drive(1, 0, 4'd0, 0, 0);
    for (int k = 0; k < MT; k++) begin
      for (int i = 0; i < 4; i++) drive(0, 1, 4'(bad[i]), 0, 0);
      idle();
      want = (k < MT - 1) ? 4'(k + 1) : 4'hF;
      checks++;
      if (Attempt_Count !== want || Fail_Pulse !== 1'b1) begin
        errors++; $display("FAIL lockout_count%0d: got cnt=%h fail=%b expected %h 1", k, Attempt_Count, Fail_Pulse, want);
      end
    end
    high_cycles = 0;
    while (Locked_Out === 1'b1 && high_cycles < 20) begin
      high_cycles++;
      drive(0, 1, 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL lockout_cycle%0d: got %h expected %h", high_cycles, dut_vec, exp_vec());
      end
    end
    checks++;
    if (high_cycles != LC || Attempt_Count !== 4'd0 || Entry_Pos !== 3'd0) begin
      errors++; $display("FAIL lockout_duration: got cycles=%0d cnt=%h pos=%0d expected %0d 0 0",
                         high_cycles, Attempt_Count, Entry_Pos, LC);
    end
    for (int i = 0; i < 4; i++) drive(0, 1, 4'(good[i]), 0, 0);
    idle();
    checks++;
    if (Unlocked !== 1'b1) begin
      errors++; $display("FAIL unlock_after_lockout: got unl=%b expected 1", Unlocked);
    end
  endtask

  task automatic test_clear_invalid();
    int bad[4] = '{5, 5, 5, 5};
    drive(1, 0, 4'd0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 4'(bad[i]), 0, 0);
    idle();
    drive(0, 1, 4'd1, 0, 0);
    drive(0, 1, 4'd2, 0, 0);
    drive(0, 1, 4'd3, 1, 0);
    checks++;
    if (Entry_Pos !== 3'd0 || Attempt_Count !== 4'd1 || Fail_Pulse !== 1'b0) begin
      errors++; $display("FAIL clear_wins: got pos=%0d cnt=%h fail=%b expected 0 1 0", Entry_Pos, Attempt_Count, Fail_Pulse);
    end
    drive(0, 1, 4'd1, 0, 0);
    drive(0, 1, 4'hA, 0, 0);
    checks++;
    if (Entry_Pos !== 3'd1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL invalid_digit: got pos=%0d expected 1", Entry_Pos);
    end
    drive(0, 1, 4'hF, 0, 0);
    drive(0, 1, 4'd2, 0, 0);
    checks++;
    if (Entry_Pos !== 3'd2) begin
      errors++; $display("FAIL digit_after_invalid: got pos=%0d expected 2", Entry_Pos);
    end
  endtask

  task automatic test_timeout_relock();
    int good[4] = '{1, 2, 3, 4};
    bit fail_seen = 0;
    drive(1, 0, 4'd0, 0, 0);
    drive(0, 1, 4'd1, 0, 0);
    drive(0, 1, 4'd2, 0, 0);
    for (int i = 0; i < ET - 1; i++) begin
      idle();
      fail_seen |= Fail_Pulse;
    end
    checks++;
    if (Entry_Pos !== 3'd2) begin
      errors++; $display("FAIL timeout_early: got pos=%0d expected 2", Entry_Pos);
    end
    idle();
    fail_seen |= Fail_Pulse;
    checks++;
    if (Entry_Pos !== 3'd0 || fail_seen || Attempt_Count !== 4'd0) begin
      errors++; $display("FAIL timeout_expire: got pos=%0d fail=%b cnt=%h expected 0 0 0", Entry_Pos, fail_seen, Attempt_Count);
    end
    for (int i = 0; i < 4; i++) drive(0, 1, 4'(good[i]), 0, 0);
    idle();
    drive(0, 1, 4'd7, 1, 0);
    checks++;
    if (Unlocked !== 1'b1 || Entry_Pos !== 3'd0) begin
      errors++; $display("FAIL unlocked_ignores: got unl=%b pos=%0d expected 1 0", Unlocked, Entry_Pos);
    end
    drive(0, 0, 4'd0, 0, 1);
    checks++;
    if (Unlocked !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL relock: got %h expected %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_reset_midway();
    int bad[4] = '{0, 0, 0, 0};
    drive(1, 0, 4'd0, 0, 0);
    for (int k = 0; k < MT; k++) begin
      for (int i = 0; i < 4; i++) drive(0, 1, 4'(bad[i]), 0, 0);
      idle();
    end
    idle();
    idle();
    checks++;
    if (Locked_Out !== 1'b1) begin
      errors++; $display("FAIL lockout_before_reset: got locked=%b expected 1", Locked_Out);
    end
    drive(1, 1, 4'd1, 0, 0);
    checks++;
    if (dut_vec !== 10'h000) begin
      errors++; $display("FAIL reset_in_lockout: got %h expected %h", dut_vec, 10'h000);
    end
    drive(0, 1, 4'd1, 0, 0);
    drive(0, 1, 4'd2, 0, 0);
    drive(1, 1, 4'd3, 0, 0);
    checks++;
    if (dut_vec !== 10'h000) begin
      errors++; $display("FAIL reset_in_entry: got %h expected %h", dut_vec, 10'h000);
    end
  endtask

  task automatic test_random();
    logic [15:0] pcv;
    logic [3:0]  d;
    int sh;
    pcv = PC;
    drive(1, 0, 4'd0, 0, 0);
    for (int n = 0; n < 1500; n++) begin
      if (m_q.size() < CL && $urandom_range(0, 3) != 0) begin
        sh = (CL - 1 - m_q.size()) * 4;
        d  = 4'((pcv >> sh) & 16'hF);
        if ($urandom_range(0, 5) == 0) d = 4'($urandom_range(0, 9));
      end else begin
        d = 4'($urandom_range(0, 15));
      end
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0, d,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d: got %h expected %h", n, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    model_step(1, 0, 4'd0, 0, 0);
    test_reset();
    test_unlock();
    test_wrong_then_right();
    test_lockout();
    test_clear_invalid();
    test_timeout_relock();
    test_reset_midway();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
